// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined LEGv8 core.
// Holds the PC, registers the fetched word into IF/ID, and owns the
// exception-link register (ELR) plus the NORMAL/HANDLER exception FSM.
// Optional feature macro: FETCH_EXC_COUNT_EN adds a saturating 16-bit
// exception counter and the exc_count_o port.
//
// state   | meaning
// NORMAL  | regular fetch; exc_i saves exc_pc_i into ELR and vectors out
// HANDLER | running the handler; eret_i returns to ELR, exc_i is nested
module fetch_stage #(
  parameter int          N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         stall_i,
  input  logic         pcsrc_i,
  input  logic [N-1:0] pcbranch_i,
  input  logic         exc_i,
  input  logic [N-1:0] exc_pc_i,
  input  logic         eret_i,
  output logic [N-1:0] imem_addr_o,
  input  logic [31:0]  imem_data_i,
  output logic [31:0]  instr_d_o,
  output logic [N-1:0] pc_d_o,
  output logic         valid_d_o,
  output logic [N-1:0] elr_o,
  output logic         in_handler_o,
`ifdef FETCH_EXC_COUNT_EN
  output logic [15:0]  exc_count_o,
`endif
  output logic         exc_nested_o
);

  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_t;

  state_t       state, state_next;
  logic [N-1:0] pc, pc_next;
  logic [N-1:0] elr_next;
  logic         eret_eff;
  logic         redirect;
  logic         nested;

  // Next-state, next-PC and ELR selection; exc_i beats eret_i, redirects beat stall
  always_comb begin
    state_next = state;
    elr_next   = elr_o;
    eret_eff   = 1'b0;
    nested     = 1'b0;
    if (exc_i) begin
      if (state == NORMAL) begin
        elr_next   = exc_pc_i;
        state_next = HANDLER;
      end else begin
        nested = 1'b1;
      end
    end else if (eret_i && state == HANDLER) begin
      eret_eff   = 1'b1;
      state_next = NORMAL;
    end

    redirect = exc_i | eret_eff | pcsrc_i;

    if (exc_i)         pc_next = EXC_VECTOR;
    else if (eret_eff) pc_next = elr_o;
    else if (pcsrc_i)  pc_next = pcbranch_i;
    else if (stall_i)  pc_next = pc;
    else               pc_next = pc + N'(4);
  end

  // PC, FSM state, ELR and the nested-exception pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= '0;
      state        <= NORMAL;
      elr_o        <= '0;
      exc_nested_o <= 1'b0;
    end else begin
      pc           <= pc_next;
      state        <= state_next;
      elr_o        <= elr_next;
      exc_nested_o <= nested;
    end
  end

  // IF/ID register: flush on any redirect, hold on stall, else capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_d_o <= '0;
      pc_d_o    <= '0;
      valid_d_o <= 1'b0;
    end else if (redirect) begin
      instr_d_o <= '0;
      pc_d_o    <= '0;
      valid_d_o <= 1'b0;
    end else if (!stall_i) begin
      instr_d_o <= imem_data_i;
      pc_d_o    <= pc;
      valid_d_o <= 1'b1;
    end
  end

`ifdef FETCH_EXC_COUNT_EN
  // Saturating count of every taken exception, nested ones included
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      exc_count_o <= '0;
    else if (exc_i && exc_count_o != 16'hFFFF)
      exc_count_o <= exc_count_o + 16'd1;
  end
`endif

  assign imem_addr_o  = pc;
  assign in_handler_o = (state == HANDLER);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns
// 0xE000_0000 | addr[31:0], so expected words are easy to hand-compute.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, pcsrc_i, exc_i, eret_i;
  logic [63:0] pcbranch_i, exc_pc_i;
  logic [63:0] imem_addr_o, pc_d_o, elr_o;
  logic [31:0] imem_data_i, instr_d_o;
  logic        valid_d_o, in_handler_o, exc_nested_o;
`ifdef FETCH_EXC_COUNT_EN
  logic [15:0] exc_count_o;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall_i      (stall_i),
    .pcsrc_i      (pcsrc_i),
    .pcbranch_i   (pcbranch_i),
    .exc_i        (exc_i),
    .exc_pc_i     (exc_pc_i),
    .eret_i       (eret_i),
    .imem_addr_o  (imem_addr_o),
    .imem_data_i  (imem_data_i),
    .instr_d_o    (instr_d_o),
    .pc_d_o       (pc_d_o),
    .valid_d_o    (valid_d_o),
    .elr_o        (elr_o),
    .in_handler_o (in_handler_o),
`ifdef FETCH_EXC_COUNT_EN
    .exc_count_o  (exc_count_o),
`endif
    .exc_nested_o (exc_nested_o)
  );

  always #5 clk = ~clk;

  assign imem_data_i = 32'hE000_0000 | imem_addr_o[31:0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_i = 0; pcsrc_i = 0; exc_i = 0; eret_i = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},    imem_addr_o, 64'h0);
    check({tag, "_instr"}, {32'h0, instr_d_o}, 64'h0);
    check({tag, "_pcd"},   pc_d_o, 64'h0);
    check({tag, "_valid"}, {63'h0, valid_d_o}, 64'h0);
    check({tag, "_elr"},   elr_o, 64'h0);
    check({tag, "_hand"},  {63'h0, in_handler_o}, 64'h0);
    check({tag, "_nest"},  {63'h0, exc_nested_o}, 64'h0);
`ifdef FETCH_EXC_COUNT_EN
    check({tag, "_cnt"},   {48'h0, exc_count_o}, 64'h0);
`endif
  endtask

  initial begin
    reset_n = 0; idle(); pcbranch_i = '0; exc_pc_i = '0;
    #23;
    check_reset("rst");
    @(negedge clk); reset_n = 1;

    // sequential fetch
    step();
    check("seq1_pc", imem_addr_o, 64'h4);
    check("seq1_instr", {32'h0, instr_d_o}, 64'hE000_0000);
    check("seq1_valid", {63'h0, valid_d_o}, 64'h1);
    step();
    check("seq2_pc", imem_addr_o, 64'h8);
    check("seq2_instr", {32'h0, instr_d_o}, 64'hE000_0004);
    check("seq2_pcd", pc_d_o, 64'h4);

    // stall two cycles at PC 8
    stall_i = 1;
    step();
    check("stall1_pc", imem_addr_o, 64'h8);
    check("stall1_instr", {32'h0, instr_d_o}, 64'hE000_0004);
    step();
    check("stall2_pc", imem_addr_o, 64'h8);
    check("stall2_pcd", pc_d_o, 64'h4);
    check("stall2_valid", {63'h0, valid_d_o}, 64'h1);

    // branch overrides stall, flushes IF/ID
    pcsrc_i = 1; pcbranch_i = 64'h40;
    step();
    check("br_pc", imem_addr_o, 64'h40);
    check("br_valid", {63'h0, valid_d_o}, 64'h0);
    check("br_instr", {32'h0, instr_d_o}, 64'h0);
    check("br_pcd", pc_d_o, 64'h0);
    idle();
    step();
    check("br2_pc", imem_addr_o, 64'h44);
    check("br2_instr", {32'h0, instr_d_o}, 64'hE000_0040);
    check("br2_valid", {63'h0, valid_d_o}, 64'h1);

    // exception from NORMAL
    exc_i = 1; exc_pc_i = 64'hC;
    step();
    check("exc_pc", imem_addr_o, 64'hD8);
    check("exc_elr", elr_o, 64'hC);
    check("exc_hand", {63'h0, in_handler_o}, 64'h1);
    check("exc_valid", {63'h0, valid_d_o}, 64'h0);
    check("exc_nest", {63'h0, exc_nested_o}, 64'h0);
    idle();
    step();
    check("exc2_pc", imem_addr_o, 64'hDC);
    check("exc2_instr", {32'h0, instr_d_o}, 64'hE000_00D8);
    check("exc2_pcd", pc_d_o, 64'hD8);

    // nested exception
    exc_i = 1; exc_pc_i = 64'hE0;
    step();
    check("nest_pc", imem_addr_o, 64'hD8);
    check("nest_elr", elr_o, 64'hC);
    check("nest_pulse", {63'h0, exc_nested_o}, 64'h1);
    idle();
    step();
    check("nest_pulse_end", {63'h0, exc_nested_o}, 64'h0);
    check("nest2_pc", imem_addr_o, 64'hDC);

    // exc and eret together in HANDLER: exc wins
    exc_i = 1; eret_i = 1; exc_pc_i = 64'h200;
    step();
    check("both_pc", imem_addr_o, 64'hD8);
    check("both_hand", {63'h0, in_handler_o}, 64'h1);
    check("both_elr", elr_o, 64'hC);
    check("both_nest", {63'h0, exc_nested_o}, 64'h1);
    idle();
    step();
    check("both2_pc", imem_addr_o, 64'hDC);

    // return from handler
    eret_i = 1;
    step();
    check("eret_pc", imem_addr_o, 64'hC);
    check("eret_hand", {63'h0, in_handler_o}, 64'h0);
    check("eret_valid", {63'h0, valid_d_o}, 64'h0);
    idle();
    step();
    check("eret2_pc", imem_addr_o, 64'h10);
    check("eret2_instr", {32'h0, instr_d_o}, 64'hE000_000C);

    // stray eret in NORMAL
    eret_i = 1;
    step();
    check("stray_pc", imem_addr_o, 64'h14);
    check("stray_valid", {63'h0, valid_d_o}, 64'h1);
    check("stray_pcd", pc_d_o, 64'h10);
    check("stray_elr", elr_o, 64'hC);
`ifdef FETCH_EXC_COUNT_EN
    check("cnt3", {48'h0, exc_count_o}, 64'h3);
`endif
    idle();

    // wrap at 2^64-4
    pcsrc_i = 1; pcbranch_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check("wrap_top", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    idle();
    step();
    check("wrap_pc", imem_addr_o, 64'h0);
    check("wrap_instr", {32'h0, instr_d_o}, 64'hFFFF_FFFC);
    check("wrap_pcd", pc_d_o, 64'hFFFF_FFFF_FFFF_FFFC);

    // mid-handler asynchronous reset
    exc_i = 1; exc_pc_i = 64'h100;
    step();
    check("mid_elr", elr_o, 64'h100);
    check("mid_hand", {63'h0, in_handler_o}, 64'h1);
`ifdef FETCH_EXC_COUNT_EN
    check("cnt4", {48'h0, exc_count_o}, 64'h4);
`endif
    idle();
    #2 reset_n = 0;
    #1 check_reset("arst");
    @(negedge clk); reset_n = 1;
    step();
    check("restart_pc", imem_addr_o, 64'h4);
    check("restart_hand", {63'h0, in_handler_o}, 64'h0);
    check("restart_instr", {32'h0, instr_d_o}, 64'hE000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined LEGv8 core with exception support.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched word into the IF/ID register; the decoder reads opcode bits [31:21] from it.
- Owns the exception-link register (ELR): redirects fetch to the exception vector on an exception and back to the ELR on ERET.
- Inserts bubbles whenever the PC is redirected.

## Interface
Parameters:
- N, 64, datapath/PC width.
- EXC_VECTOR, 64'h0000_0000_0000_00D8, exception handler entry address.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold PC and IF/ID (hazard unit).
- pcsrc_i  in  1  taken branch/CBZ resolved downstream.
- pcbranch_i  in  N  branch target.
- exc_i  in  1  exception request (one cycle per event).
- exc_pc_i  in  N  PC of the faulting instruction.
- eret_i  in  1  ERET decoded (decoder ERet flag, qualified valid).
- imem_addr_o  out  N  current PC to instruction memory.
- imem_data_i  in  32  instruction word (combinational read of imem_addr_o).
- instr_d_o  out  32  IF/ID instruction.
- pc_d_o  out  N  IF/ID PC.
- valid_d_o  out  1  IF/ID holds a real instruction.
- elr_o  out  N  exception-link register.
- in_handler_o  out  1  FSM is in HANDLER.
- exc_nested_o  out  1  one-cycle pulse: exception taken while in HANDLER.
- exc_count_o  out  16  saturating exception count; present only with FETCH_EXC_COUNT_EN.

## Operation
- Reset values (all outputs, asynchronous on reset_n low):
  - PC = 0, so imem_addr_o = 0.
  - instr_d_o = 0, pc_d_o = 0, valid_d_o = 0.
  - elr_o = 0, in_handler_o = 0, exc_nested_o = 0.
  - exc_count_o = 0.
- FSM states: NORMAL, HANDLER.
  - NORMAL + exc_i: ELR <= exc_pc_i; go to HANDLER.
  - HANDLER + exc_i: ELR unchanged; exc_nested_o = 1 for one cycle; stay in HANDLER.
  - HANDLER + eret_i: go to NORMAL.
  - NORMAL + eret_i: ignored; treat as no redirect.
- Next-PC priority, highest first:
  - exc_i: EXC_VECTOR.
  - eret_i in HANDLER: ELR (the value before any same-cycle update).
  - pcsrc_i: pcbranch_i.
  - stall_i: PC held.
  - otherwise: PC + 4.
- Redirects override stall_i.
- Arithmetic: PC + 4 is modulo 2^N and wraps silently. No alignment check.
- IF/ID register update:
  - On a redirect (exc_i, effective eret_i, or pcsrc_i): flush. instr_d_o = 0, valid_d_o = 0, pc_d_o = 0. An all-zero opcode decodes to all-zero controls.
  - On stall_i with no redirect: hold all IF/ID fields.
  - Otherwise: instr_d_o <= imem_data_i, pc_d_o <= PC, valid_d_o <= 1.
- Simultaneous exc_i and eret_i: exc_i wins. If in HANDLER, this is a nested exception: stay in HANDLER, ELR unchanged.

## Timing
- Fetch latency is 1 cycle: a word addressed in cycle t appears on instr_d_o after edge t+1.
- Redirect penalty:
  - Redirect inputs are sampled at edge t.
  - The new PC is on imem_addr_o after edge t.
  - The first valid target instruction is in IF/ID after edge t+1.
  - Exactly one bubble follows the redirect edge.
- ELR is updated at the same edge the exception is taken. elr_o reflects the new value in the following cycle.
- in_handler_o changes at the same edge as the PC redirect.
- A reset_n assertion mid-operation aborts any pending redirect. After release, fetch restarts at PC 0 in NORMAL.

## Configuration
- FETCH_EXC_COUNT_EN defined:
  - Adds a 16-bit counter and the exc_count_o port.
  - Counter increments on every taken exc_i, nested included.
  - Saturates at 16'hFFFF; reset to 0.
- FETCH_EXC_COUNT_EN undefined:
  - No counter and no port.
  - All other behaviour is identical.

## Test plan
- Reset and sequential fetch:
  - Release reset_n with no control inputs.
  - imem_addr_o steps 0, 4, 8, C.
  - instr_d_o follows the memory words one cycle late; valid_d_o = 1 from the second edge.
- Branch with stall:
  - Hold stall_i for 2 cycles at PC = 8: PC and IF/ID hold.
  - Then assert pcsrc_i = 1, pcbranch_i = 40 together with stall_i: next PC = 40 and IF/ID is flushed (valid_d_o = 0, instr_d_o = 0).
- Exception and return:
  - At PC = 10, assert exc_i with exc_pc_i = C: PC = D8, elr_o = C, in_handler_o = 1, one bubble.
  - Later assert eret_i: PC = C, in_handler_o = 0.
- Nested and simultaneous events:
  - In HANDLER, assert exc_i with exc_pc_i = E0: elr_o stays C, exc_nested_o pulses, PC = D8.
  - Assert exc_i and eret_i together: exc_i wins.
- Stray ERET and wrap:
  - eret_i in NORMAL: PC just increments.
  - PC at 2^N − 4 with no redirect: PC wraps to 0.
- Counter and mid-operation reset:
  - With FETCH_EXC_COUNT_EN, 3 exceptions: exc_count_o = 3.
  - Pulse reset_n low mid-handler: all outputs return to their reset values immediately.
